div_unit: RTL and testbench

Multi-cycle RV32M divide/remainder unit in the execute stage. It consumes the two operands read from the register file and produces a 32-bit result with its destination register index. Its one-cycle `done` pulse drives the register-file write port (write-enable, write-address, write-data). Radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/div_unit_pkg.sv | 15 +
 rtl/div_unit.sv | 98 +++++++++
 tb/tb_div_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared op encodings, FSM states and constants for the RV32M divider
package div_unit_pkg;
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;
  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring RV32M DIV/DIVU/REM/REMU unit
//   clk, rst_n          clock, async active-low reset
//   start, op, rs1_data, rs2_data, rd_addr   request and operands (sampled when not busy)
//   flush               synchronous abort
//   busy, done          iterating / one-cycle result-valid pulse (register-file write-enable)
//   result, rd_addr_out write-data / write-address, held until the next completion
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [4:0]       rd_addr,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_addr_out
);
  div_state_e       state_q;
  logic             rem_op_q, qneg_q, rneg_q;
  logic [4:0]       cnt_q, rd_q, rd_out_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q, result_q;
  logic             is_signed, is_rem, dvs_zero, ovf, accept, last;
  logic [WIDTH-1:0] a_abs, b_abs, special_d, quot_d, rem_d, final_d;
  logic [WIDTH:0]   shift_d, diff_d;
  always_comb begin
    is_signed = op == DIV_OP_DIV || op == DIV_OP_REM;
    is_rem    = op == DIV_OP_REM || op == DIV_OP_REMU;
    a_abs     = is_signed && rs1_data[WIDTH-1] ? -rs1_data : rs1_data;
    b_abs     = is_signed && rs2_data[WIDTH-1] ? -rs2_data : rs2_data;
    dvs_zero  = rs2_data == '0;
    ovf       = is_signed && rs1_data == INT_MIN && rs2_data == ALL_ONES;
    special_d = dvs_zero ? (is_rem ? rs1_data : ALL_ONES) : (is_rem ? '0 : INT_MIN);
    accept    = start && !flush && state_q != ST_CALC;
    // 33-bit trial subtract: shifted partial remainder can exceed 32 bits before subtraction
    shift_d   = {rem_q, dvd_q[WIDTH-1]};
    diff_d    = shift_d - {1'b0, dvs_q};
    rem_d     = diff_d[WIDTH] ? shift_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
    // dividend register doubles as the quotient: bits shift out the top, quotient bits in the bottom
    quot_d    = {dvd_q[WIDTH-2:0], ~diff_d[WIDTH]};
    final_d   = rem_op_q ? (rneg_q ? -rem_d : rem_d) : (qneg_q ? -quot_d : quot_d);
    last      = cnt_q == 5'(DIV_ITERS - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rem_op_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else if (accept) begin
      rem_op_q <= is_rem;
      qneg_q   <= op == DIV_OP_DIV && (rs1_data[WIDTH-1] ^ rs2_data[WIDTH-1]);
      rneg_q   <= op == DIV_OP_REM && rs1_data[WIDTH-1];
      rd_q     <= rd_addr;
      dvd_q    <= a_abs;
      dvs_q    <= b_abs;
      rem_q    <= '0;
      cnt_q    <= '0;
      if (dvs_zero || ovf) begin
        result_q <= special_d;
        rd_out_q <= rd_addr;
        state_q  <= ST_DONE;
      end else begin
        state_q <= ST_CALC;
      end
    end else if (state_q == ST_CALC) begin
      dvd_q <= quot_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + 5'd1;
      if (last) begin
        result_q <= final_d;
        rd_out_q <= rd_q;
        state_q  <= ST_DONE;
      end
    end else begin
      state_q <= ST_IDLE;
    end
  end
  assign busy        = state_q == ST_CALC;
  assign done        = state_q == ST_DONE;
  assign result      = result_q;
  assign rd_addr_out = rd_out_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
  import div_unit_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;
  int checks = 0;
  int failures = 0;
  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .rd_addr(rd_addr), .flush(flush), .busy(busy),
    .done(done), .result(result), .rd_addr_out(rd_addr_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // drive a request at the current time; returns just after the accept edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  // latency counts edges after the accept edge; returns at the negedge where done is seen
  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res, input logic [4:0] exp_rd);
    int n;
    logic saw_busy;
    saw_busy = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (done) break;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_rd"}, 32'(rd_addr_out), 32'(exp_rd));
    chk({tag, "_busy"}, 32'(saw_busy), 32'(exp_lat != 0));
  endtask
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input int exp_lat, input logic [31:0] exp_res);
    issue(o, a, b, rd);
    wait_done(tag, exp_lat, exp_res, rd);
  endtask
  initial begin
    int cnt, lat;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", result, 0);
    chk("rst_rd", 32'(rd_addr_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 5'd5, 32, 32'd14);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    run("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 5'd6, 32, 32'd2);
    run("div_m7_2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32, 32'hFFFF_FFFD);
    run("rem_m7_2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32, 32'hFFFF_FFFF);
    run("rem_7_m2", DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd9, 32, 32'd1);
    run("div_5_0", DIV_OP_DIV, 32'd5, 32'd0, 5'd10, 0, 32'hFFFF_FFFF);
    run("remu_5_0", DIV_OP_REMU, 32'd5, 32'd0, 5'd11, 0, 32'd5);
    run("div_ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 32'h8000_0000);
    run("rem_ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, 32'd0);
    run("divu_max_1", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd14, 32, 32'hFFFF_FFFF);
    run("divu_rd0", DIV_OP_DIVU, 32'd9, 32'd3, 5'd0, 32, 32'd3);
    @(negedge clk);
    issue(DIV_OP_DIVU, 32'd1000, 32'd10, 5'd3);
    rs1_data = 32'd50; rs2_data = 32'd5; rd_addr = 5'd4;
    cnt = 0; lat = -1;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      start = (n == 5);
      if (done) begin
        cnt++;
        if (lat < 0) lat = n;
      end
    end
    chk("ignore_cnt", 32'(cnt), 1);
    chk("ignore_lat", 32'(lat), 32);
    chk("ignore_res", result, 32'd100);
    chk("ignore_rd", 32'(rd_addr_out), 32'd3);
    run("b2b_first", DIV_OP_DIVU, 32'd81, 32'd9, 5'd15, 32, 32'd9);
    run("b2b_second", DIV_OP_REMU, 32'd83, 32'd9, 5'd16, 32, 32'd2);
    @(negedge clk);
    issue(DIV_OP_DIVU, 32'd1000, 32'd10, 5'd17);
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; start = 1'b0;
    chk("flush_busy", 32'(busy), 0);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("flush_no_done", 32'(cnt), 0);
    chk("flush_res", result, 32'd2);
    chk("flush_rd", 32'(rd_addr_out), 32'd16);
    issue(DIV_OP_DIVU, 32'd1000, 32'd10, 5'd18);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_res", result, 0);
    chk("arst_rd", 32'(rd_addr_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("after_rst", DIV_OP_DIVU, 32'd9, 32'd3, 5'd19, 32, 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
